gpu_tex_fill_sched: RTL and testbench

- Fill scheduler that sits between the texture pipeline controller and the VRAM memory arbiter.
- Serves two requesters that share one VRAM read port:
  - texture-cache line fills, raised on a texel miss;
  - CLUT loads, raised at primitive setup when a palette format is used.
- Issues one 64-bit read at a time, writes the returned data into the Tex$ line or the CLUT RAM, and pulses the matching completion signal that releases the pipeline pause.

---
 rtl/gpu_tex_fill_sched.sv | 226 ++++++++++++++++++++++
 tb/tb_gpu_tex_fill_sched.sv | 494 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_tex_fill_sched.sv
// Fill scheduler: serialises Tex$ line fills and CLUT loads onto one VRAM read port.
// Optional GPU_CLUT_SKIP_EN skips CLUT reloads that match the last completed load.
module gpu_tex_fill_sched #(
    parameter int unsigned CLUT_WORDS_4BPP = 4,
    parameter int unsigned CLUT_WORDS_8BPP = 64
) (
    input  logic        clk,
    input  logic        i_nrst,
    input  logic        i_texFillReq,
    input  logic [16:0] i_texFillAdr,
    output logic        o_texFillComplete,
    output logic        o_texWrite,
    output logic [16:0] o_texWrAdr,
    output logic [63:0] o_texWrData,
    input  logic        i_clutLoadReq,
    input  logic [5:0]  i_clutX,
    input  logic [8:0]  i_clutY,
    input  logic        i_clut8bpp,
`ifdef GPU_CLUT_SKIP_EN
    input  logic        i_clutInvalidate,
`endif
    output logic        o_clutWrite,
    output logic [5:0]  o_clutWrIdx,
    output logic [63:0] o_clutWrData,
    output logic        o_clutLoadComplete,
    output logic        o_busy,
    output logic        o_memReq,
    output logic [16:0] o_memAdr,
    input  logic        i_memAck,
    input  logic        i_memDataValid,
    input  logic [63:0] i_memData
);

    typedef enum logic [2:0] {
        IDLE, TX_REQ, TX_WAIT, TX_DONE, CL_REQ, CL_WAIT, CL_DONE
    } state_t;

    localparam logic [5:0] LAST_4BPP = 6'(CLUT_WORDS_4BPP - 1);
    localparam logic [5:0] LAST_8BPP = 6'(CLUT_WORDS_8BPP - 1);

    state_t      state_q, state_d;
    logic [16:0] tex_adr_q, tex_adr_d;
    logic [5:0]  word_cnt_q, word_cnt_d;
    logic        pend_q, pend_d;
    logic [5:0]  pend_x_q, pend_x_d;
    logic [8:0]  pend_y_q, pend_y_d;
    logic        pend_8bpp_q, pend_8bpp_d;
    logic [5:0]  act_x_q, act_x_d;
    logic [8:0]  act_y_q, act_y_d;
    logic        act_8bpp_q, act_8bpp_d;

    logic        eff_pend;
    logic [5:0]  eff_x;
    logic [8:0]  eff_y;
    logic        eff_8bpp;
    logic [7:0]  clut_lo;
    logic [5:0]  last_word;

`ifdef GPU_CLUT_SKIP_EN
    logic [5:0]  last_x_q, last_x_d;
    logic [8:0]  last_y_q, last_y_d;
    logic        last_8bpp_q, last_8bpp_d;
    logic        last_vld_q, last_vld_d;
    logic        stale_q, stale_d;
    logic        param_hit;
`endif

    always_comb begin
        // A pulse in this cycle counts as pending so it wins arbitration against a simultaneous tex miss.
        eff_pend  = pend_q | i_clutLoadReq;
        eff_x     = i_clutLoadReq ? i_clutX    : pend_x_q;
        eff_y     = i_clutLoadReq ? i_clutY    : pend_y_q;
        eff_8bpp  = i_clutLoadReq ? i_clut8bpp : pend_8bpp_q;
        clut_lo   = {act_x_q, 2'b00} + {2'b00, word_cnt_q};
        last_word = act_8bpp_q ? LAST_8BPP : LAST_4BPP;

        state_d     = state_q;
        tex_adr_d   = tex_adr_q;
        word_cnt_d  = word_cnt_q;
        pend_d      = eff_pend;
        pend_x_d    = eff_x;
        pend_y_d    = eff_y;
        pend_8bpp_d = eff_8bpp;
        act_x_d     = act_x_q;
        act_y_d     = act_y_q;
        act_8bpp_d  = act_8bpp_q;
`ifdef GPU_CLUT_SKIP_EN
        param_hit   = last_vld_q && !i_clutInvalidate && (eff_x == last_x_q) &&
                      (eff_y == last_y_q) && (eff_8bpp == last_8bpp_q);
        last_x_d    = last_x_q;
        last_y_d    = last_y_q;
        last_8bpp_d = last_8bpp_q;
        last_vld_d  = last_vld_q & ~i_clutInvalidate;
        stale_d     = stale_q | i_clutInvalidate;
`endif

        o_texFillComplete  = 1'b0;
        o_texWrite         = 1'b0;
        o_texWrAdr         = '0;
        o_texWrData        = '0;
        o_clutWrite        = 1'b0;
        o_clutWrIdx        = '0;
        o_clutWrData       = '0;
        o_clutLoadComplete = 1'b0;
        o_busy             = (state_q != IDLE);
        o_memReq           = 1'b0;
        o_memAdr           = '0;

        case (state_q)
            IDLE: begin
                if (eff_pend) begin
                    pend_d     = 1'b0;
                    act_x_d    = eff_x;
                    act_y_d    = eff_y;
                    act_8bpp_d = eff_8bpp;
                    word_cnt_d = '0;
                    state_d    = CL_REQ;
`ifdef GPU_CLUT_SKIP_EN
                    stale_d    = i_clutInvalidate;
                    if (param_hit) state_d = CL_DONE;
`endif
                end else if (i_texFillReq) begin
                    tex_adr_d = i_texFillAdr;
                    state_d   = TX_REQ;
                end
            end
            TX_REQ: begin
                o_memReq = 1'b1;
                o_memAdr = tex_adr_q;
                if (i_memAck) state_d = TX_WAIT;
            end
            TX_WAIT: begin
                if (i_memDataValid) begin
                    o_texWrite  = 1'b1;
                    o_texWrAdr  = tex_adr_q;
                    o_texWrData = i_memData;
                    state_d     = TX_DONE;
                end
            end
            TX_DONE: begin
                o_texFillComplete = 1'b1;
                state_d           = IDLE;
            end
            CL_REQ: begin
                o_memReq = 1'b1;
                o_memAdr = {act_y_q, clut_lo};
                if (i_memAck) state_d = CL_WAIT;
            end
            CL_WAIT: begin
                if (i_memDataValid) begin
                    o_clutWrite  = 1'b1;
                    o_clutWrIdx  = word_cnt_q;
                    o_clutWrData = i_memData;
                    if (eff_pend) begin
                        pend_d     = 1'b0;
                        act_x_d    = eff_x;
                        act_y_d    = eff_y;
                        act_8bpp_d = eff_8bpp;
                        word_cnt_d = '0;
                        state_d    = CL_REQ;
`ifdef GPU_CLUT_SKIP_EN
                        stale_d    = i_clutInvalidate;
`endif
                    end else if (word_cnt_q == last_word) begin
                        state_d = CL_DONE;
                    end else begin
                        word_cnt_d = word_cnt_q + 6'd1;
                        state_d    = CL_REQ;
                    end
                end
            end
            CL_DONE: begin
                o_clutLoadComplete = 1'b1;
                state_d            = IDLE;
`ifdef GPU_CLUT_SKIP_EN
                last_x_d    = act_x_q;
                last_y_d    = act_y_q;
                last_8bpp_d = act_8bpp_q;
                last_vld_d  = ~stale_q & ~i_clutInvalidate;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_nrst) begin
            state_q     <= IDLE;
            tex_adr_q   <= '0;
            word_cnt_q  <= '0;
            pend_q      <= 1'b0;
            pend_x_q    <= '0;
            pend_y_q    <= '0;
            pend_8bpp_q <= 1'b0;
            act_x_q     <= '0;
            act_y_q     <= '0;
            act_8bpp_q  <= 1'b0;
`ifdef GPU_CLUT_SKIP_EN
            last_x_q    <= '0;
            last_y_q    <= '0;
            last_8bpp_q <= 1'b0;
            last_vld_q  <= 1'b0;
            stale_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            tex_adr_q   <= tex_adr_d;
            word_cnt_q  <= word_cnt_d;
            pend_q      <= pend_d;
            pend_x_q    <= pend_x_d;
            pend_y_q    <= pend_y_d;
            pend_8bpp_q <= pend_8bpp_d;
            act_x_q     <= act_x_d;
            act_y_q     <= act_y_d;
            act_8bpp_q  <= act_8bpp_d;
`ifdef GPU_CLUT_SKIP_EN
            last_x_q    <= last_x_d;
            last_y_q    <= last_y_d;
            last_8bpp_q <= last_8bpp_d;
            last_vld_q  <= last_vld_d;
            stale_q     <= stale_d;
`endif
        end
    end

endmodule

// File: tb/tb_gpu_tex_fill_sched.sv
// Directed bench for gpu_tex_fill_sched with a one-outstanding-read VRAM responder.
// Builds with or without GPU_CLUT_SKIP_EN.
module tb_gpu_tex_fill_sched;

    logic        clk = 1'b0;
    logic        i_nrst;
    logic        i_texFillReq;
    logic [16:0] i_texFillAdr;
    logic        o_texFillComplete;
    logic        o_texWrite;
    logic [16:0] o_texWrAdr;
    logic [63:0] o_texWrData;
    logic        i_clutLoadReq;
    logic [5:0]  i_clutX;
    logic [8:0]  i_clutY;
    logic        i_clut8bpp;
`ifdef GPU_CLUT_SKIP_EN
    logic        i_clutInvalidate;
`endif
    logic        o_clutWrite;
    logic [5:0]  o_clutWrIdx;
    logic [63:0] o_clutWrData;
    logic        o_clutLoadComplete;
    logic        o_busy;
    logic        o_memReq;
    logic [16:0] o_memAdr;
    logic        i_memAck;
    logic        i_memDataValid;
    logic [63:0] i_memData;

    always #5 clk = ~clk;

    gpu_tex_fill_sched #(
        .CLUT_WORDS_4BPP(4),
        .CLUT_WORDS_8BPP(64)
    ) dut (
        .clk               (clk),
        .i_nrst            (i_nrst),
        .i_texFillReq      (i_texFillReq),
        .i_texFillAdr      (i_texFillAdr),
        .o_texFillComplete (o_texFillComplete),
        .o_texWrite        (o_texWrite),
        .o_texWrAdr        (o_texWrAdr),
        .o_texWrData       (o_texWrData),
        .i_clutLoadReq     (i_clutLoadReq),
        .i_clutX           (i_clutX),
        .i_clutY           (i_clutY),
        .i_clut8bpp        (i_clut8bpp),
`ifdef GPU_CLUT_SKIP_EN
        .i_clutInvalidate  (i_clutInvalidate),
`endif
        .o_clutWrite       (o_clutWrite),
        .o_clutWrIdx       (o_clutWrIdx),
        .o_clutWrData      (o_clutWrData),
        .o_clutLoadComplete(o_clutLoadComplete),
        .o_busy            (o_busy),
        .o_memReq          (o_memReq),
        .o_memAdr          (o_memAdr),
        .i_memAck          (i_memAck),
        .i_memDataValid    (i_memDataValid),
        .i_memData         (i_memData)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // VRAM responder state: ack after ack_wait request cycles, data lat cycles after ack
    int          lat      = 1;
    int          ack_wait = 0;
    int          dcnt     = -1;
    int          req_age  = 0;
    logic [16:0] rd_adr   = '0;
    logic [63:0] data_base = '0;
    bit          prev_ack = 1'b0;
    logic [16:0] prev_adr = '0;
    int          unstable = 0;
    int          req_after_ack = 0;
    int          overlap  = 0;

    logic [16:0] req_q[$];
    int          req_cyc_q[$];
    logic [16:0] txw_adr_q[$];
    logic [63:0] txw_dat_q[$];
    logic [5:0]  clw_idx_q[$];
    logic [63:0] clw_dat_q[$];
    int          tex_done, clut_done, tex_done_cyc, clut_done_cyc;

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        i_memAck       = 1'b0;
        i_memDataValid = 1'b0;
        i_memData      = '0;
        if (dcnt == 0) begin
            i_memDataValid = 1'b1;
            i_memData      = data_base ^ {47'b0, rd_adr};
            dcnt           = -1;
        end else if (dcnt > 0) begin
            dcnt--;
        end
        if (o_memReq) begin
            if (prev_ack) req_after_ack++;
            if (req_age > 0 && o_memAdr != prev_adr) unstable++;
            if (req_age >= ack_wait) begin
                i_memAck = 1'b1;
                if (dcnt != -1) overlap++;
                rd_adr = o_memAdr;
                dcnt   = lat - 1;
                req_q.push_back(o_memAdr);
                req_cyc_q.push_back(cyc);
                req_age = 0;
            end else begin
                req_age++;
            end
        end else begin
            req_age = 0;
        end
        prev_ack = i_memAck;
        prev_adr = o_memAdr;
        #1;
        if (o_texWrite) begin
            txw_adr_q.push_back(o_texWrAdr);
            txw_dat_q.push_back(o_texWrData);
        end
        if (o_clutWrite) begin
            clw_idx_q.push_back(o_clutWrIdx);
            clw_dat_q.push_back(o_clutWrData);
        end
        if (o_texFillComplete) begin
            tex_done++;
            tex_done_cyc = cyc;
        end
        if (o_clutLoadComplete) begin
            clut_done++;
            clut_done_cyc = cyc;
        end
    endtask

    task automatic clear_logs();
        req_q.delete();
        req_cyc_q.delete();
        txw_adr_q.delete();
        txw_dat_q.delete();
        clw_idx_q.delete();
        clw_dat_q.delete();
        tex_done = 0;
        clut_done = 0;
        tex_done_cyc = 0;
        clut_done_cyc = 0;
    endtask

    task automatic pulse_clut(input logic [5:0] x, input logic [8:0] y, input logic b8);
        i_clutLoadReq = 1'b1;
        i_clutX       = x;
        i_clutY       = y;
        i_clut8bpp    = b8;
        cycle();
        i_clutLoadReq = 1'b0;
    endtask

    task automatic wait_clut(input int bound);
        for (int i = 0; i < bound && clut_done == 0; i++) cycle();
        n_tests++;
        if (clut_done == 0) begin
            n_fail++;
            $display("FAIL clut_timeout: no complete pulse within %0d cycles", bound);
        end
    endtask

    task automatic test_reset();
        i_nrst = 1'b0;
        cycle();
        i_clutLoadReq = 1'b1;
        i_clutX = 6'd9;
        i_clutY = 9'd9;
        cycle();
        i_clutLoadReq = 1'b0;
        n_tests++;
        if ({o_busy, o_memReq, o_texWrite, o_clutWrite, o_texFillComplete, o_clutLoadComplete} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {o_busy, o_memReq, o_texWrite, o_clutWrite, o_texFillComplete, o_clutLoadComplete});
        end
        n_tests++;
        if (o_memAdr !== 17'h0 || o_texWrAdr !== 17'h0 || o_clutWrIdx !== 6'h0) begin
            n_fail++;
            $display("FAIL reset_addr: got %h/%h/%h expected 0/0/0", o_memAdr, o_texWrAdr, o_clutWrIdx);
        end
        n_tests++;
        if (o_texWrData !== 64'h0 || o_clutWrData !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h/%h expected 0/0", o_texWrData, o_clutWrData);
        end
        i_nrst = 1'b1;
        clear_logs();
        repeat (3) cycle();
        n_tests++;
        if (o_busy !== 1'b0 || req_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_pend_cleared: busy=%b reads=%0d expected 0/0", o_busy, req_q.size());
        end
    endtask

    task automatic test_tex_fill();
        int k;
        clear_logs();
        lat = 3;
        ack_wait = 0;
        data_base = 64'h0123456789AA6622;
        i_texFillAdr = 17'h1ABCD;
        i_texFillReq = 1'b1;
        k = cyc;
        for (int i = 0; i < 50 && tex_done == 0; i++) cycle();
        n_tests++;
        if (tex_done == 0) begin
            n_fail++;
            $display("FAIL tex_timeout: no complete pulse within 50 cycles");
        end
        cycle();
        i_texFillReq = 1'b0;
        repeat (4) cycle();
        n_tests++;
        if (tex_done != 1) begin
            n_fail++;
            $display("FAIL tex_done_count: got %0d expected 1", tex_done);
        end
        n_tests++;
        if (tex_done_cyc != k + 5) begin
            n_fail++;
            $display("FAIL tex_latency: got %0d expected %0d", tex_done_cyc - k, 5);
        end
        n_tests++;
        if (req_q.size() != 1 || req_q[0] !== 17'h1ABCD) begin
            n_fail++;
            $display("FAIL tex_reads: got %0d reads first %h expected 1 read 1abcd", req_q.size(), req_q[0]);
        end
        n_tests++;
        if (txw_adr_q.size() != 1 || txw_adr_q[0] !== 17'h1ABCD || txw_dat_q[0] !== 64'h0123456789ABCDEF) begin
            n_fail++;
            $display("FAIL tex_write: got %0d writes %h %h expected 1 write 1abcd 0123456789abcdef",
                     txw_adr_q.size(), txw_adr_q[0], txw_dat_q[0]);
        end
    endtask

    task automatic test_clut_4bpp();
        logic [16:0] exp_adr[4] = '{17'h00A14, 17'h00A15, 17'h00A16, 17'h00A17};
        clear_logs();
        lat = 2;
        ack_wait = 1;
        data_base = 64'hC100_0000_0000_0000;
        pulse_clut(6'd5, 9'd10, 1'b0);
        wait_clut(100);
        repeat (3) cycle();
        n_tests++;
        if (req_q.size() != 4 || clw_idx_q.size() != 4 || clut_done != 1) begin
            n_fail++;
            $display("FAIL clut4_counts: got reads=%0d writes=%0d done=%0d expected 4/4/1",
                     req_q.size(), clw_idx_q.size(), clut_done);
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (req_q[i] !== exp_adr[i] || clw_idx_q[i] !== 6'(i) ||
                clw_dat_q[i] !== (data_base ^ {47'b0, exp_adr[i]})) begin
                n_fail++;
                $display("FAIL clut4_beat%0d: got adr %h idx %0d data %h expected adr %h idx %0d",
                         i, req_q[i], clw_idx_q[i], clw_dat_q[i], exp_adr[i], i);
            end
        end
    endtask

    task automatic test_clut_8bpp();
        logic [7:0]  lo;
        logic [16:0] exp;
        clear_logs();
        lat = 1;
        ack_wait = 0;
        data_base = 64'h5A5A_0000_1111_0000;
        pulse_clut(6'd63, 9'd1, 1'b1);
        wait_clut(400);
        repeat (3) cycle();
        n_tests++;
        if (req_q.size() != 64 || clw_idx_q.size() != 64 || clut_done != 1) begin
            n_fail++;
            $display("FAIL clut8_counts: got reads=%0d writes=%0d done=%0d expected 64/64/1",
                     req_q.size(), clw_idx_q.size(), clut_done);
        end
        n_tests++;
        if (req_q[0] !== 17'h001FC || req_q[3] !== 17'h001FF || req_q[4] !== 17'h00100 || req_q[63] !== 17'h0013B) begin
            n_fail++;
            $display("FAIL clut8_wrap: got %h %h %h %h expected 001fc 001ff 00100 0013b",
                     req_q[0], req_q[3], req_q[4], req_q[63]);
        end
        n_tests++;
        if (clw_idx_q[63] !== 6'd63) begin
            n_fail++;
            $display("FAIL clut8_last_idx: got %0d expected 63", clw_idx_q[63]);
        end
        for (int i = 0; i < 64; i++) begin
            lo  = 8'hFC + 8'(i);
            exp = {9'd1, lo};
            n_tests++;
            if (req_q[i] !== exp || clw_idx_q[i] !== 6'(i) || clw_dat_q[i] !== (data_base ^ {47'b0, exp})) begin
                n_fail++;
                $display("FAIL clut8_beat%0d: got adr %h idx %0d expected adr %h idx %0d",
                         i, req_q[i], clw_idx_q[i], exp, i);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] exp_adr[5] = '{17'h00308, 17'h00309, 17'h0030A, 17'h0030B, 17'h00555};
        clear_logs();
        lat = 1;
        ack_wait = 0;
        data_base = 64'h0;
        i_texFillReq = 1'b1;
        i_texFillAdr = 17'h00555;
        pulse_clut(6'd2, 9'd3, 1'b0);
        for (int i = 0; i < 100 && tex_done == 0; i++) cycle();
        cycle();
        i_texFillReq = 1'b0;
        repeat (4) cycle();
        n_tests++;
        if (clut_done != 1 || tex_done != 1) begin
            n_fail++;
            $display("FAIL b2b_done_counts: got clut=%0d tex=%0d expected 1/1", clut_done, tex_done);
        end
        n_tests++;
        if (req_q.size() != 5) begin
            n_fail++;
            $display("FAIL b2b_read_count: got %0d expected 5", req_q.size());
        end
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (req_q[i] !== exp_adr[i]) begin
                n_fail++;
                $display("FAIL b2b_read%0d: got %h expected %h", i, req_q[i], exp_adr[i]);
            end
        end
        n_tests++;
        if (req_cyc_q[4] != clut_done_cyc + 2 || tex_done_cyc <= clut_done_cyc) begin
            n_fail++;
            $display("FAIL b2b_order: tex read at %0d clut done at %0d tex done at %0d expected read at done+2",
                     req_cyc_q[4], clut_done_cyc, tex_done_cyc);
        end
        n_tests++;
        if (txw_adr_q.size() != 1 || txw_adr_q[0] !== 17'h00555) begin
            n_fail++;
            $display("FAIL b2b_tex_write: got %0d writes adr %h expected 1 write 00555", txw_adr_q.size(), txw_adr_q[0]);
        end
    endtask

    task automatic test_restart();
        logic [16:0] exp_adr[6] = '{17'h00A14, 17'h00A15, 17'h00204, 17'h00205, 17'h00206, 17'h00207};
        logic [5:0]  exp_idx[6] = '{6'd0, 6'd1, 6'd0, 6'd1, 6'd2, 6'd3};
        clear_logs();
        lat = 2;
        ack_wait = 0;
        pulse_clut(6'd5, 9'd10, 1'b0);
        for (int i = 0; i < 50 && req_q.size() < 2; i++) cycle();
        pulse_clut(6'd1, 9'd2, 1'b0);
        wait_clut(100);
        repeat (3) cycle();
        n_tests++;
        if (req_q.size() != 6 || clw_idx_q.size() != 6 || clut_done != 1) begin
            n_fail++;
            $display("FAIL restart_counts: got reads=%0d writes=%0d done=%0d expected 6/6/1",
                     req_q.size(), clw_idx_q.size(), clut_done);
        end
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (req_q[i] !== exp_adr[i] || clw_idx_q[i] !== exp_idx[i]) begin
                n_fail++;
                $display("FAIL restart_beat%0d: got adr %h idx %0d expected adr %h idx %0d",
                         i, req_q[i], clw_idx_q[i], exp_adr[i], exp_idx[i]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        clear_logs();
        lat = 5;
        ack_wait = 0;
        pulse_clut(6'd5, 9'd10, 1'b0);
        for (int i = 0; i < 50 && req_q.size() < 2; i++) cycle();
        cycle();
        i_nrst = 1'b0;
        cycle();
        n_tests++;
        if ({o_busy, o_memReq, o_clutWrite, o_clutLoadComplete} !== 4'b0 || o_memAdr !== 17'h0) begin
            n_fail++;
            $display("FAIL midreset_idle: got flags %b adr %h expected 0000 00000",
                     {o_busy, o_memReq, o_clutWrite, o_clutLoadComplete}, o_memAdr);
        end
        i_nrst = 1'b1;
        repeat (8) cycle();
        n_tests++;
        if (clw_idx_q.size() != 1 || clut_done != 0 || req_q.size() != 2 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_late_data: got writes=%0d done=%0d reads=%0d busy=%b expected 1/0/2/0",
                     clw_idx_q.size(), clut_done, req_q.size(), o_busy);
        end
    endtask

`ifdef GPU_CLUT_SKIP_EN
    task automatic test_clut_skip();
        int k;
        clear_logs();
        lat = 1;
        ack_wait = 0;
        pulse_clut(6'd5, 9'd10, 1'b0);
        wait_clut(100);
        repeat (2) cycle();
        n_tests++;
        if (req_q.size() != 4) begin
            n_fail++;
            $display("FAIL skip_first_load: got %0d reads expected 4", req_q.size());
        end
        clear_logs();
        k = cyc;
        pulse_clut(6'd5, 9'd10, 1'b0);
        wait_clut(20);
        repeat (2) cycle();
        n_tests++;
        if (req_q.size() != 0 || clut_done != 1 || clut_done_cyc != k + 1) begin
            n_fail++;
            $display("FAIL skip_hit: got reads=%0d done=%0d latency=%0d expected 0/1/1",
                     req_q.size(), clut_done, clut_done_cyc - k);
        end
        i_clutInvalidate = 1'b1;
        cycle();
        i_clutInvalidate = 1'b0;
        clear_logs();
        pulse_clut(6'd5, 9'd10, 1'b0);
        wait_clut(100);
        repeat (2) cycle();
        n_tests++;
        if (req_q.size() != 4) begin
            n_fail++;
            $display("FAIL skip_invalidate: got %0d reads expected 4", req_q.size());
        end
        clear_logs();
        pulse_clut(6'd5, 9'd10, 1'b1);
        wait_clut(400);
        repeat (2) cycle();
        n_tests++;
        if (req_q.size() != 64) begin
            n_fail++;
            $display("FAIL skip_bpp_mismatch: got %0d reads expected 64", req_q.size());
        end
    endtask
`endif

    task automatic test_protocol();
        n_tests++;
        if (unstable != 0 || req_after_ack != 0 || overlap != 0) begin
            n_fail++;
            $display("FAIL protocol: got unstable=%0d req_after_ack=%0d overlap=%0d expected 0/0/0",
                     unstable, req_after_ack, overlap);
        end
    endtask

    initial begin
        i_nrst = 1'b0;
        i_texFillReq = 1'b0;
        i_texFillAdr = '0;
        i_clutLoadReq = 1'b0;
        i_clutX = '0;
        i_clutY = '0;
        i_clut8bpp = 1'b0;
`ifdef GPU_CLUT_SKIP_EN
        i_clutInvalidate = 1'b0;
`endif
        i_memAck = 1'b0;
        i_memDataValid = 1'b0;
        i_memData = '0;
        test_reset();
        test_tex_fill();
        test_clut_4bpp();
        test_clut_8bpp();
        test_back_to_back();
        test_restart();
        test_reset_midflight();
`ifdef GPU_CLUT_SKIP_EN
        test_clut_skip();
`endif
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
